// File: rtl/freq_meas_scheduler.sv
// rtl/freq_meas_scheduler.sv - round-robin time-sharing of one frequency core across NUM_CH inputs
module freq_meas_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int FREQ_W         = 26,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 150_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH-1:0]         waveform_in,
  output logic                      core_waveform,
  output logic                      core_rst,
  input  logic                      core_done,
  input  logic [FREQ_W-1:0]         core_freq,
  input  logic [$clog2(NUM_CH)-1:0] rd_ch,
  output logic [FREQ_W-1:0]         rd_freq,
  output logic                      rd_valid,
  output logic                      rd_timeout,
  output logic [$clog2(NUM_CH)-1:0] cur_ch,
  output logic                      busy,
  output logic                      sweep_done
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + RST_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_MEASURE, S_STORE} state_t;
  state_t state, state_nxt;

  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   sel_ch;
  logic              above;
  logic [CNT_W-1:0]  cnt;
  logic [FREQ_W-1:0] res_q;
  logic              res_to;
  logic [FREQ_W-1:0] freq_mem [NUM_CH];
  logic [NUM_CH-1:0] valid_bits;
  logic [NUM_CH-1:0] to_bits;

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Descending offset scan so the nearest enabled channel at/after ptr wins.
  always_comb begin
    sel_ch = '0;
    above  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en[wrap_add(ptr, i)]) sel_ch = wrap_add(ptr, i);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (i > int'(cur_ch) && ch_en[i]) above = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run && |ch_en) state_nxt = S_SELECT;
      S_SELECT:  state_nxt = (|ch_en) ? S_SETTLE : S_IDLE;
      S_SETTLE:  if (cnt == RST_LAST) state_nxt = S_MEASURE;
      S_MEASURE: if (core_done || cnt == TO_LAST) state_nxt = S_STORE;
      S_STORE:   state_nxt = run ? S_SELECT : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    core_rst = (state != S_MEASURE);
    busy     = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= '0;
      cur_ch        <= '0;
      cnt           <= '0;
      res_q         <= '0;
      res_to        <= 1'b0;
      core_waveform <= 1'b0;
      sweep_done    <= 1'b0;
    end else begin
      core_waveform <= waveform_in[cur_ch];
      cnt           <= (state_nxt != state) ? '0 : cnt + 1'b1;
      sweep_done    <= (state == S_STORE) && !above;
      if (state == S_IDLE) ptr <= '0;
      if (state == S_STORE) ptr <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
      if (state == S_SELECT && |ch_en) cur_ch <= sel_ch;
      // Captured every MEASURE cycle; the exit cycle's value is what STORE writes.
      if (state == S_MEASURE) begin
        res_q  <= core_done ? core_freq : '0;
        res_to <= !core_done;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_bits <= '0;
      to_bits    <= '0;
      for (int i = 0; i < NUM_CH; i++) freq_mem[i] <= '0;
      rd_freq    <= '0;
      rd_valid   <= 1'b0;
      rd_timeout <= 1'b0;
    end else begin
      if (state == S_STORE) begin
        freq_mem[cur_ch]   <= res_q;
        valid_bits[cur_ch] <= 1'b1;
        to_bits[cur_ch]    <= res_to;
      end
      if (state == S_STORE && rd_ch == cur_ch) begin
        rd_freq    <= res_q;
        rd_valid   <= 1'b1;
        rd_timeout <= res_to;
      end else begin
        rd_freq    <= freq_mem[rd_ch];
        rd_valid   <= valid_bits[rd_ch];
        rd_timeout <= to_bits[rd_ch];
      end
    end
  end

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// tb/tb_freq_meas_scheduler.sv - self-checking bench for freq_meas_scheduler with a behavioural core stub
module tb_freq_meas_scheduler;

  localparam int NCH   = 4;
  localparam int TO    = 2000;
  localparam int NEVER = 1_000_000;
  localparam int GAP   = 6;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [3:0]  ch_en, waveform_in;
  logic        core_waveform, core_rst, core_done;
  logic [25:0] core_freq;
  logic [1:0]  rd_ch, cur_ch;
  logic [25:0] rd_freq;
  logic        rd_valid, rd_timeout, busy, sweep_done;

  int total = 0;
  int bad   = 0;

  int dly[NCH];
  int scnt = 0;
  int ch_q[$];
  int len_q[$];
  int gap_q[$];
  int sweep_cnt = 0;
  int sweep_ch  = -1;
  int low_cnt   = 0;
  int high_cnt  = 0;
  bit prev_rst  = 1'b1;
  bit have_prev = 1'b0;

  freq_meas_scheduler #(.NUM_CH(4), .FREQ_W(26), .RST_CYCLES(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .run(run), .ch_en(ch_en), .waveform_in(waveform_in),
    .core_waveform(core_waveform), .core_rst(core_rst), .core_done(core_done),
    .core_freq(core_freq), .rd_ch(rd_ch), .rd_freq(rd_freq), .rd_valid(rd_valid),
    .rd_timeout(rd_timeout), .cur_ch(cur_ch), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  // Core stub: counts cycles out of reset, reports ch*1000+7 once the per-channel delay is hit.
  always @(posedge clk) begin
    if (core_rst) scnt <= 0;
    else          scnt <= scnt + 1;
  end
  assign core_done = !core_rst && (scnt == dly[cur_ch]);
  assign core_freq = 26'(int'(cur_ch) * 1000 + 7);

  initial begin
    waveform_in = 4'b0;
    forever begin
      @(posedge clk);
      #3;
      waveform_in = 4'($urandom);
    end
  end

  always @(negedge clk) begin
    if (core_rst) begin
      if (!prev_rst) begin
        len_q.push_back(low_cnt);
        have_prev = 1'b1;
        high_cnt  = 0;
      end
      high_cnt++;
    end else begin
      if (prev_rst) begin
        ch_q.push_back(int'(cur_ch));
        if (have_prev) gap_q.push_back(high_cnt);
        low_cnt = 0;
      end
      low_cnt++;
    end
    if (sweep_done) begin
      sweep_cnt++;
      sweep_ch = (ch_q.size() > 0) ? ch_q[ch_q.size() - 1] : -1;
    end
    if (!busy) have_prev = 1'b0;
    prev_rst = core_rst;
  end

  function automatic int ch_at(input int i);
    return (i < ch_q.size()) ? ch_q[i] : -1;
  endfunction
  function automatic int len_at(input int i);
    return (i < len_q.size()) ? len_q[i] : -1;
  endfunction
  function automatic int exp_len(input int d);
    return (d >= TO) ? TO : d + 1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  task automatic rd(input int ch, output logic [25:0] f, output logic v, output logic t);
    rd_ch = 2'(ch);
    step(1);
    f = rd_freq;
    v = rd_valid;
    t = rd_timeout;
  endtask

  task automatic wait_starts(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (ch_q.size() >= target) ok = 1'b1;
      else step(1);
    end
  endtask

  task automatic wait_lens(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (len_q.size() >= target) ok = 1'b1;
      else step(1);
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else step(1);
    end
    step(2);
  endtask

  task automatic test_reset;
    logic [25:0] f; logic v, t;
    run = 1'b0; ch_en = 4'b0;
    do_reset(5);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reset_core_rst got=%0b want=1", core_rst); end
    total++; if (cur_ch !== 2'd0) begin bad++; $display("FAIL reset_cur_ch got=%0d want=0", cur_ch); end
    total++; if (sweep_done !== 1'b0) begin bad++; $display("FAIL reset_sweep_done got=%0b want=0", sweep_done); end
    total++; if (core_waveform !== 1'b0) begin bad++; $display("FAIL reset_core_waveform got=%0b want=0", core_waveform); end
    for (int c = 0; c < NCH; c++) begin
      rd(c, f, v, t);
      total++; if (v !== 1'b0 || f !== 26'd0 || t !== 1'b0)
        begin bad++; $display("FAIL reset_rd%0d got=v%0b/f%0d/t%0b want=v0/f0/t0", c, v, f, t); end
    end
  endtask

  task automatic test_sweep;
    int exp_seq[4];
    int cb, lb, gb, sb;
    bit ok;
    logic [25:0] f; logic v, t;
    exp_seq = '{0, 1, 3, 0};
    cb = ch_q.size(); lb = len_q.size(); gb = gap_q.size(); sb = sweep_cnt;
    for (int c = 0; c < NCH; c++) dly[c] = 500;
    ch_en = 4'b1011; run = 1'b1;
    wait_starts(cb + 4, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL sweep_wait got=%0d starts want=4", ch_q.size() - cb); end
    for (int k = 0; k < 4; k++) begin
      total++; if (ch_at(cb + k) != exp_seq[k])
        begin bad++; $display("FAIL sweep_seq%0d got=%0d want=%0d", k, ch_at(cb + k), exp_seq[k]); end
    end
    total++; if (sweep_cnt - sb != 1) begin bad++; $display("FAIL sweep_count got=%0d want=1", sweep_cnt - sb); end
    total++; if (sweep_ch != 3) begin bad++; $display("FAIL sweep_after_ch got=%0d want=3", sweep_ch); end
    for (int k = 0; k < 3; k++) begin
      total++; if (len_at(lb + k) != 501)
        begin bad++; $display("FAIL sweep_len%0d got=%0d want=501", k, len_at(lb + k)); end
    end
    for (int k = gb; k < gap_q.size(); k++) begin
      total++; if (gap_q[k] != GAP) begin bad++; $display("FAIL sweep_gap got=%0d want=%0d", gap_q[k], GAP); end
    end
    run = 1'b0;
    wait_idle(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL sweep_idle got=busy want=idle"); end
    for (int k = cb; k < ch_q.size(); k++) begin
      total++; if (ch_q[k] == 2) begin bad++; $display("FAIL sweep_ch2_selected got=2 want=never"); end
    end
    rd(3, f, v, t);
    total++; if (f !== 26'd3007 || v !== 1'b1 || t !== 1'b0)
      begin bad++; $display("FAIL sweep_rd3 got=f%0d/v%0b/t%0b want=f3007/v1/t0", f, v, t); end
    rd(2, f, v, t);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL sweep_rd2_valid got=%0b want=0", v); end
  endtask

  task automatic test_waveform_mux;
    logic exp;
    bit ok;
    ch_en = 4'b1111; run = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      exp = waveform_in[cur_ch];
      step(1);
      total++; if (core_waveform !== exp)
        begin bad++; $display("FAIL wave_mux cyc%0d got=%0b want=%0b", i, core_waveform, exp); end
    end
    run = 1'b0;
    wait_idle(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL wave_idle got=busy want=idle"); end
  endtask

  task automatic test_timeout;
    int cb, lb, gb, sb;
    bit ok;
    logic [25:0] f; logic v, t;
    cb = ch_q.size(); lb = len_q.size(); gb = gap_q.size(); sb = sweep_cnt;
    dly[1] = NEVER; ch_en = 4'b0010; run = 1'b1;
    wait_lens(lb + 2, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_wait got=%0d want=2", len_q.size() - lb); end
    step(2);
    for (int k = 0; k < 2; k++) begin
      total++; if (len_at(lb + k) != TO) begin bad++; $display("FAIL to_len%0d got=%0d want=%0d", k, len_at(lb + k), TO); end
      total++; if (ch_at(cb + k) != 1) begin bad++; $display("FAIL to_ch%0d got=%0d want=1", k, ch_at(cb + k)); end
    end
    total++; if (sweep_cnt - sb != 2) begin bad++; $display("FAIL to_b2b_sweeps got=%0d want=2", sweep_cnt - sb); end
    for (int k = gb; k < gap_q.size(); k++) begin
      total++; if (gap_q[k] != GAP) begin bad++; $display("FAIL to_gap got=%0d want=%0d", gap_q[k], GAP); end
    end
    run = 1'b0;
    wait_idle(2500, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_idle got=busy want=idle"); end
    rd(1, f, v, t);
    total++; if (f !== 26'd0 || v !== 1'b1 || t !== 1'b1)
      begin bad++; $display("FAIL to_rd1 got=f%0d/v%0b/t%0b want=f0/v1/t1", f, v, t); end
    dly[1] = 500;
  endtask

  task automatic test_coincide;
    int cb, lb;
    bit ok;
    logic [25:0] f; logic v, t;
    cb = ch_q.size(); lb = len_q.size();
    dly[2] = TO - 1; ch_en = 4'b0100; run = 1'b1;
    wait_starts(cb + 1, 100, ok);
    run = 1'b0;
    wait_idle(2500, ok);
    total++; if (!ok) begin bad++; $display("FAIL coin_idle got=busy want=idle"); end
    total++; if (len_at(lb) != TO) begin bad++; $display("FAIL coin_len got=%0d want=%0d", len_at(lb), TO); end
    rd(2, f, v, t);
    total++; if (f !== 26'd2007 || v !== 1'b1 || t !== 1'b0)
      begin bad++; $display("FAIL coin_rd2 got=f%0d/v%0b/t%0b want=f2007/v1/t0", f, v, t); end
    dly[2] = 500;
  endtask

  task automatic test_read_bypass;
    bit ok, seen;
    do_reset(2);
    dly[0] = 50; ch_en = 4'b0001; rd_ch = 2'd0; run = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); if (!core_rst) seen = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 200 && seen && !ok; i++) begin @(negedge clk); if (core_rst) ok = 1'b1; end
    step(1);
    total++; if (!ok) begin bad++; $display("FAIL byp_wait got=no_store want=store"); end
    total++; if (rd_freq !== 26'd7 || rd_valid !== 1'b1)
      begin bad++; $display("FAIL byp_rd0 got=f%0d/v%0b want=f7/v1", rd_freq, rd_valid); end
    run = 1'b0;
    wait_idle(500, ok);
    dly[0] = 500;
  endtask

  task automatic test_run_drop;
    int cb;
    bit ok;
    logic [25:0] f; logic v, t;
    do_reset(2);
    cb = ch_q.size();
    ch_en = 4'b1111; run = 1'b1;
    wait_starts(cb + 2, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_wait got=%0d want=2", ch_q.size() - cb); end
    step(100);
    run = 1'b0;
    wait_idle(1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_idle got=busy want=idle"); end
    total++; if (ch_q.size() - cb != 2) begin bad++; $display("FAIL drop_starts got=%0d want=2", ch_q.size() - cb); end
    total++; if (busy !== 1'b0 || core_rst !== 1'b1)
      begin bad++; $display("FAIL drop_state got=busy%0b/rst%0b want=busy0/rst1", busy, core_rst); end
    rd(1, f, v, t);
    total++; if (f !== 26'd1007 || v !== 1'b1 || t !== 1'b0)
      begin bad++; $display("FAIL drop_rd1 got=f%0d/v%0b/t%0b want=f1007/v1/t0", f, v, t); end
    rd(2, f, v, t);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL drop_rd2_valid got=%0b want=0", v); end
  endtask

  task automatic test_reset_mid;
    int cb, nb;
    bit ok;
    logic [25:0] f; logic v, t;
    cb = ch_q.size();
    ch_en = 4'b1111; run = 1'b1;
    wait_starts(cb + 1, 1000, ok);
    step(50);
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL rmid_measuring got=%0b want=0", core_rst); end
    reset = 1'b1; ch_en = 4'b0;
    step(1);
    reset = 1'b0;
    total++; if (busy !== 1'b0 || core_rst !== 1'b1 || cur_ch !== 2'd0)
      begin bad++; $display("FAIL rmid_state got=busy%0b/rst%0b/ch%0d want=busy0/rst1/ch0", busy, core_rst, cur_ch); end
    for (int c = 0; c < NCH; c++) begin
      rd(c, f, v, t);
      total++; if (v !== 1'b0) begin bad++; $display("FAIL rmid_valid%0d got=%0b want=0", c, v); end
    end
    nb = 0;
    repeat (20) begin step(1); if (busy !== 1'b0) nb++; end
    total++; if (nb != 0) begin bad++; $display("FAIL rmid_stay_idle got=%0d busy_cycles want=0", nb); end
    run = 1'b0;
  endtask

  task automatic test_random;
    int ord[$];
    int cb, lb, gb, sb, m, n, hi, ch, nsw;
    bit ok;
    logic [3:0] en;
    logic [25:0] f; logic v, t;
    for (int it = 0; it < 3; it++) begin
      do_reset(2);
      en = 4'($urandom_range(1, 15));
      for (int c = 0; c < NCH; c++) dly[c] = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
      ord.delete();
      for (int c = 0; c < NCH; c++) if (en[c]) ord.push_back(c);
      n = ord.size(); hi = ord[n - 1];
      cb = ch_q.size(); lb = len_q.size(); gb = gap_q.size(); sb = sweep_cnt;
      ch_en = en; run = 1'b1;
      wait_lens(lb + 5, 5 * (TO + 10) + 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL rnd%0d_wait got=%0d want=5", it, len_q.size() - lb); end
      run = 1'b0;
      wait_idle(TO + 200, ok);
      total++; if (!ok) begin bad++; $display("FAIL rnd%0d_idle got=busy want=idle", it); end
      m = ch_q.size() - cb;
      nsw = 0;
      for (int k = 0; k < m; k++) begin
        ch = ord[k % n];
        if (ch == hi) nsw++;
        total++; if (ch_at(cb + k) != ch)
          begin bad++; $display("FAIL rnd%0d_seq%0d got=%0d want=%0d", it, k, ch_at(cb + k), ch); end
        total++; if (len_at(lb + k) != exp_len(dly[ch]))
          begin bad++; $display("FAIL rnd%0d_len%0d got=%0d want=%0d", it, k, len_at(lb + k), exp_len(dly[ch])); end
      end
      total++; if (sweep_cnt - sb != nsw)
        begin bad++; $display("FAIL rnd%0d_sweeps got=%0d want=%0d", it, sweep_cnt - sb, nsw); end
      for (int k = gb; k < gap_q.size(); k++) begin
        total++; if (gap_q[k] != GAP) begin bad++; $display("FAIL rnd%0d_gap got=%0d want=%0d", it, gap_q[k], GAP); end
      end
      for (int c = 0; c < NCH; c++) begin
        logic [25:0] ef; logic ev, et;
        ev = en[c];
        et = en[c] && (dly[c] >= TO);
        ef = (en[c] && dly[c] < TO) ? 26'(c * 1000 + 7) : 26'd0;
        rd(c, f, v, t);
        total++; if (f !== ef || v !== ev || t !== et)
          begin bad++; $display("FAIL rnd%0d_rd%0d got=f%0d/v%0b/t%0b want=f%0d/v%0b/t%0b", it, c, f, v, t, ef, ev, et); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; ch_en = 4'b0; rd_ch = 2'd0;
    for (int c = 0; c < NCH; c++) dly[c] = 500;
    test_reset;
    test_sweep;
    test_waveform_mux;
    test_timeout;
    test_coincide;
    test_read_bypass;
    test_run_drop;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
